// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern, selectable overlap, and a saturating match counter.
// Latency: z is registered one cycle after the completing bit; no backpressure (en qualifies each bit).
module seq_detect_param #(
    parameter int                PAT_W   = 3,
    parameter logic [PAT_W-1:0]  PATTERN = 3'b101,
    parameter int                CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clear,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sat
);

    localparam int              FILL_W  = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  next_hist;
    logic [FILL_W-1:0] next_fill;
    logic              hit;

    // fill counts bits consumed since the last restart, saturating at PAT_W
    always_comb begin
        next_hist = {hist[PAT_W-2:0], x};
        next_fill = (fill == FILL_MAX) ? fill : fill + 1'b1;
        hit       = (next_fill == FILL_MAX) && (next_hist == pat);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat       <= PATTERN;
            hist      <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            sat       <= 1'b0;
        end else if (clear) begin
            hist      <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
            sat       <= 1'b0;
        end else if (pat_load) begin
            pat  <= pat_in;
            hist <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else if (en) begin
            hist <= next_hist;
            z    <= hit;
            fill <= (hit && !overlap) ? '0 : next_fill;
            if (hit && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == CNT_MAX - 1'b1)
                    sat <= 1'b1;
            end
        end else begin
            z <= 1'b0;
        end
    end

endmodule
